// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-4 registered stream demultiplexer.
// Provides lane count, select width, per-lane counter width and the
// holding-register state encoding used by demux_1to4_pipe.
package demux_pkg;

  localparam int unsigned LANES = 4;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned CNT_W = 8;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

endpackage : demux_pkg

// File: rtl/demux_lane_counter.sv
// One wrapping transfer counter for a single demux lane.
// Ports:
//   i_clk   - clock, counts on rising edge
//   i_rst_n - synchronous active-low clear
//   i_inc   - increment enable (one lane drain this cycle)
//   o_cnt   - current count, wraps from all-ones to zero
module demux_lane_counter
  import demux_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  // Natural binary wrap, no saturation.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule : demux_lane_counter

// File: rtl/demux_1to4_pipe.sv
// Registered 1-to-4 stream demultiplexer with valid/ready handshake.
// A beat (select + data) is captured in a single-entry holding register
// and presented on exactly one of four output lanes the following cycle.
// Ports:
//   CLK, RST_N          - clock, synchronous active-low reset
//   IN_VALID/IN_READY   - input handshake (IN_READY is combinational)
//   IN_SEL, IN_DATA     - destination lane and data word
//   OUT_VALID[3:0]      - one-hot lane valid
//   OUT_READY[3:0]      - per-lane consumer ready
//   OUT_DATA            - lane k at [k*WIDTH +: WIDTH], idle lanes driven 0
//   CNT[31:0]           - per-lane 8-bit drain counters (DEMUX_COUNT_EN only)
// Optional feature macro: DEMUX_COUNT_EN
module demux_1to4_pipe
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  input  logic [SEL_W-1:0]       IN_SEL,
  input  logic [WIDTH-1:0]       IN_DATA,
  output logic [LANES-1:0]       OUT_VALID,
  input  logic [LANES-1:0]       OUT_READY,
  output logic [LANES*WIDTH-1:0] OUT_DATA
`ifdef DEMUX_COUNT_EN
  ,
  output logic [LANES*CNT_W-1:0] CNT
`endif
);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [WIDTH-1:0]   r_data;
  logic [SEL_W-1:0]   r_sel;
  logic               w_load;
  logic               w_drain;

  // State and holding register; reset discards any held beat.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= ST_EMPTY;
      r_data  <= '0;
      r_sel   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_data <= IN_DATA;
        r_sel  <= IN_SEL;
      end
    end
  end

  // Next state, ready and load/drain strobes. Only the selected lane's
  // ready matters; a drain frees the slot for a same-edge accept.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_drain     = 1'b0;
    IN_READY    = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        IN_READY = RST_N;
        w_load   = IN_VALID & RST_N;
        if (w_load) begin
          w_state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        w_drain  = OUT_READY[r_sel];
        IN_READY = RST_N & w_drain;
        w_load   = IN_VALID & RST_N & w_drain;
        if (w_drain && !w_load) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
  end

  // Lane decode of the holding register: one-hot valid, zero on idle lanes.
  always_comb begin
    OUT_VALID = '0;
    OUT_DATA  = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      if (r_state == ST_FULL && r_sel == SEL_W'(k)) begin
        OUT_VALID[k]               = 1'b1;
        OUT_DATA[k*WIDTH +: WIDTH] = r_data;
      end
    end
  end

`ifdef DEMUX_COUNT_EN
  logic [LANES-1:0] w_lane_drain;

  // Drain strobe split per lane for the counters.
  always_comb begin
    w_lane_drain = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      w_lane_drain[k] = w_drain & (r_sel == SEL_W'(k));
    end
  end

  for (genvar g = 0; g < int'(LANES); g++) begin : g_cnt
    demux_lane_counter u_cnt (
      .i_clk   (CLK),
      .i_rst_n (RST_N),
      .i_inc   (w_lane_drain[g]),
      .o_cnt   (CNT[g*CNT_W +: CNT_W])
    );
  end
`endif

endmodule : demux_1to4_pipe

// File: tb/tb_demux_1to4_pipe.sv
// Self-checking bench for demux_1to4_pipe. Expected behaviour comes from
// a queue-based scoreboard: accepted beats are pushed, drained beats are
// popped, and the head of the queue defines what the lanes must show.
// Optional feature macro: DEMUX_COUNT_EN
module tb_demux_1to4_pipe;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        IN_VALID;
  logic        IN_READY;
  logic [1:0]  IN_SEL;
  logic [7:0]  IN_DATA;
  logic [3:0]  OUT_VALID;
  logic [3:0]  OUT_READY;
  logic [31:0] OUT_DATA;
`ifdef DEMUX_COUNT_EN
  logic [31:0] CNT;
  int          mdl_cnt [4];
`endif

  typedef struct packed {
    logic [1:0] sel;
    logic [7:0] data;
  } beat_t;

  beat_t q [$];
  int    n_checks = 0;
  int    n_errors = 0;

  always #5 CLK = ~CLK;

  demux_1to4_pipe #(.WIDTH(8)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_SEL    (IN_SEL),
    .IN_DATA   (IN_DATA),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_DATA  (OUT_DATA)
`ifdef DEMUX_COUNT_EN
    ,
    .CNT       (CNT)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle, check outputs mid-cycle, then advance the scoreboard.
  task automatic step(input logic v, input logic [1:0] s, input logic [7:0] d,
                      input logic [3:0] ordy, input logic rn);
    logic [3:0]  e_valid;
    logic [31:0] e_data;
    logic        e_ready;
    beat_t       b;
    IN_VALID  = v;
    IN_SEL    = s;
    IN_DATA   = d;
    OUT_READY = ordy;
    RST_N     = rn;
    #4;
    e_valid = '0;
    e_data  = '0;
    e_ready = rn;
    if (q.size() != 0) begin
      e_valid = 4'b0001 << q[0].sel;
      e_data  = 32'(q[0].data) << (8 * int'(q[0].sel));
      e_ready = rn && ordy[q[0].sel];
    end
    check("in_ready",  64'(IN_READY),  64'(e_ready));
    check("out_valid", 64'(OUT_VALID), 64'(e_valid));
    check("out_data",  64'(OUT_DATA),  64'(e_data));
`ifdef DEMUX_COUNT_EN
    check("cnt", 64'(CNT), 64'({8'(mdl_cnt[3]), 8'(mdl_cnt[2]), 8'(mdl_cnt[1]), 8'(mdl_cnt[0])}));
`endif
    @(posedge CLK);
    if (!rn) begin
      q.delete();
`ifdef DEMUX_COUNT_EN
      foreach (mdl_cnt[k]) mdl_cnt[k] = 0;
`endif
    end else begin
      if (q.size() != 0 && ordy[q[0].sel]) begin
`ifdef DEMUX_COUNT_EN
        mdl_cnt[q[0].sel] = (mdl_cnt[q[0].sel] + 1) % 256;
`endif
        void'(q.pop_front());
      end
      if (v && e_ready) begin
        b.sel  = s;
        b.data = d;
        q.push_back(b);
      end
    end
    #1;
  endtask

  initial begin
    RST_N     = 1'b0;
    IN_VALID  = 1'b1;
    IN_SEL    = 2'd1;
    IN_DATA   = 8'hFF;
    OUT_READY = 4'b1111;
`ifdef DEMUX_COUNT_EN
    foreach (mdl_cnt[k]) mdl_cnt[k] = 0;
`endif
    @(posedge CLK);
    #1;

    // Reset held with a valid beat offered, then release and idle.
    step(1'b1, 2'd1, 8'hFF, 4'b1111, 1'b0);
    step(1'b0, 2'd0, 8'h00, 4'b1111, 1'b1);

    // Routing sweep at full rate.
    for (int i = 0; i < 4; i++) step(1'b1, 2'(i), 8'(8'hA0 + i), 4'b1111, 1'b1);
    step(1'b0, 2'd0, 8'h00, 4'b1111, 1'b1);

    // Backpressure on lane 2, then drain and accept on the same edge.
    step(1'b1, 2'd2, 8'h5C, 4'b1111, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 2'd0, 8'h33, 4'b1011, 1'b1);
    step(1'b1, 2'd0, 8'h33, 4'b1111, 1'b1);
    step(1'b0, 2'd0, 8'h00, 4'b1111, 1'b1);

    // Lane 1 held while the other lanes are ready.
    step(1'b1, 2'd1, 8'h77, 4'b1111, 1'b1);
    for (int i = 0; i < 2; i++) step(1'b1, 2'd3, 8'h11, 4'b1101, 1'b1);
    step(1'b0, 2'd0, 8'h00, 4'b1111, 1'b1);
    step(1'b0, 2'd0, 8'h00, 4'b1111, 1'b1);

    // Reset while lane 3 is stalled; the beat must not come back.
    step(1'b1, 2'd3, 8'hE3, 4'b1111, 1'b1);
    step(1'b0, 2'd0, 8'h00, 4'b0111, 1'b1);
    step(1'b0, 2'd0, 8'h00, 4'b0111, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 8'h00, 4'b1111, 1'b1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) != 0), 2'($urandom), 8'($urandom),
           4'($urandom), ($urandom_range(0, 63) != 0));
    end

`ifdef DEMUX_COUNT_EN
    // Counter wrap: 257 drains on lane 0, 3 on lane 2.
    step(1'b0, 2'd0, 8'h00, 4'b1111, 1'b0);
    for (int i = 0; i < 257; i++) step(1'b1, 2'd0, 8'(i), 4'b1111, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, 2'd2, 8'(i), 4'b1111, 1'b1);
    step(1'b0, 2'd0, 8'h00, 4'b1111, 1'b1);
    step(1'b0, 2'd0, 8'h00, 4'b1111, 1'b1);
    check("cnt_wrap", 64'(CNT), 64'(32'h0003_0001));
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_demux_1to4_pipe
